// File: rtl/priority_arb_n_v.sv
// N-input registered priority arbiter with a valid/ready grant hold.
// MODE 0 grants the lowest set index; MODE 1 rotates from a pointer past the last accepted grant.
module priority_arb_n_v #(
  parameter int N     = 4,
  parameter int IDX_W = 2,
  parameter int MODE  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx,
  output logic [N-1:0]     o_gnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             accept;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] win;
  logic             found;

  assign accept  = (state_q == HOLD) && i_ready;
  // Re-arbitration on an accepting edge must already see the advanced pointer.
  assign ptr_nxt = !accept ? ptr_q :
                   (idx_q == IDX_W'(N-1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    int k;
    win   = '0;
    found = 1'b0;
    k     = 0;
    for (int off = 0; off < N; off++) begin
      k = (MODE == 1) ? int'(ptr_nxt) + off : off;
      if (k >= N) k = k - N;
      if (!found && i_req[k]) begin
        found = 1'b1;
        win   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    if (MODE == 1) ptr_d = ptr_nxt;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          state_d    = HOLD;
          idx_d      = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
        end
      end
      HOLD: begin
        if (accept) begin
          if (|i_req) begin
            idx_d      = win;
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = (state_q == HOLD);
  assign o_idx   = idx_q;
  assign o_gnt   = gnt_q;

endmodule

// File: tb/tb_priority_arb_n_v.sv
// Directed bench for priority_arb_n_v: fixed (N=4), round-robin (N=4) and round-robin (N=3).
// Accepted grants are checked against a per-instance queue of hand-computed indices.
module tb_priority_arb_n_v;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  logic       rst0, rdy0, v0;
  logic [3:0] req0, gnt0;
  logic [1:0] idx0;
  logic       rst1, rdy1, v1;
  logic [3:0] req1, gnt1;
  logic [1:0] idx1;
  logic       rst2, rdy2, v2;
  logic [2:0] req2, gnt2;
  logic [1:0] idx2;

  int q0[$];
  int q1[$];
  int q2[$];

  priority_arb_n_v #(.N(4), .IDX_W(2), .MODE(0)) u0 (
    .i_clk(clk), .i_rst_n(rst0), .i_req(req0), .i_ready(rdy0),
    .o_valid(v0), .o_idx(idx0), .o_gnt(gnt0));
  priority_arb_n_v #(.N(4), .IDX_W(2), .MODE(1)) u1 (
    .i_clk(clk), .i_rst_n(rst1), .i_req(req1), .i_ready(rdy1),
    .o_valid(v1), .o_idx(idx1), .o_gnt(gnt1));
  priority_arb_n_v #(.N(3), .IDX_W(2), .MODE(1)) u2 (
    .i_clk(clk), .i_rst_n(rst2), .i_req(req2), .i_ready(rdy2),
    .o_valid(v2), .o_idx(idx2), .o_gnt(gnt2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [1:0] idx,
                         input logic [3:0] gnt, input int ev, input int eidx);
    chk({nm, "_valid"}, 32'(v), 32'(ev));
    chk({nm, "_idx"}, 32'(idx), (ev != 0) ? 32'(eidx) : 32'd0);
    chk({nm, "_gnt"}, 32'(gnt), (ev != 0) ? (32'd1 << eidx) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: an acceptance is o_valid & i_ready seen before the coming edge.
  always @(negedge clk) begin
    int e;
    if (rst0 && v0 && rdy0) begin
      if (q0.size() == 0) begin
        vectors++; fails++;
        $display("FAIL u0_extra_grant: got idx %0d expected none", idx0);
      end else begin
        e = q0.pop_front();
        chk("u0_acc_idx", 32'(idx0), 32'(e));
        chk("u0_acc_gnt", 32'(gnt0), 32'd1 << e);
      end
    end
  end

  always @(negedge clk) begin
    int e;
    if (rst1 && v1 && rdy1) begin
      if (q1.size() == 0) begin
        vectors++; fails++;
        $display("FAIL u1_extra_grant: got idx %0d expected none", idx1);
      end else begin
        e = q1.pop_front();
        chk("u1_acc_idx", 32'(idx1), 32'(e));
        chk("u1_acc_gnt", 32'(gnt1), 32'd1 << e);
      end
    end
  end

  always @(negedge clk) begin
    int e;
    if (rst2 && v2 && rdy2) begin
      if (q2.size() == 0) begin
        vectors++; fails++;
        $display("FAIL u2_extra_grant: got idx %0d expected none", idx2);
      end else begin
        e = q2.pop_front();
        chk("u2_acc_idx", 32'(idx2), 32'(e));
        chk("u2_acc_gnt", 32'(gnt2), 32'd1 << e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst0 = 1'b0; req0 = 4'hF; rdy0 = 1'b1;
    rst1 = 1'b0; req1 = 4'hF; rdy1 = 1'b1;
    rst2 = 1'b0; req2 = 3'b111; rdy2 = 1'b1;

    // T1: reset held with all requests and ready active
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("t1_reset", v0, idx0, gnt0, 0, 0);
    end

    // T2: fixed priority, grant held while ready low
    rst0 = 1'b1; req0 = 4'b1010; rdy0 = 1'b0;
    tick();
    chk_out("t2_first", v0, idx0, gnt0, 1, 1);
    req0 = 4'b0001;
    tick();
    chk_out("t2_hold_a", v0, idx0, gnt0, 1, 1);
    tick();
    chk_out("t2_hold_b", v0, idx0, gnt0, 1, 1);
    q0.push_back(1);
    rdy0 = 1'b1;
    tick();
    chk_out("t2_regrant", v0, idx0, gnt0, 1, 0);
    q0.push_back(0);
    req0 = 4'b0000;
    tick();
    chk_out("t2_idle", v0, idx0, gnt0, 0, 0);

    // T3: back-to-back grants of idx 2, then drop
    req0 = 4'b1100;
    tick();
    chk_out("t3_first", v0, idx0, gnt0, 1, 2);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(2);
      tick();
      chk_out("t3_b2b", v0, idx0, gnt0, 1, 2);
    end
    q0.push_back(2);
    req0 = 4'b0000;
    tick();
    chk_out("t3_drop", v0, idx0, gnt0, 0, 0);

    // T6 (fixed): reset mid-grant, regrant one cycle after release
    req0 = 4'b0100; rdy0 = 1'b0;
    tick();
    chk_out("t6f_hold", v0, idx0, gnt0, 1, 2);
    rst0 = 1'b0;
    tick();
    chk_out("t6f_reset", v0, idx0, gnt0, 0, 0);
    rst0 = 1'b1;
    tick();
    chk_out("t6f_regrant", v0, idx0, gnt0, 1, 2);

    // T4/T5: round-robin wrap then skip
    rst1 = 1'b1;
    tick();
    chk_out("t4_first", v1, idx1, gnt1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      q1.push_back(i);
      tick();
    end
    req1 = 4'b1001;
    q1.push_back(0);
    tick();
    chk_out("t5_skip", v1, idx1, gnt1, 1, 3);
    q1.push_back(3);
    tick();
    chk_out("t5_wrap", v1, idx1, gnt1, 1, 0);
    // leave ptr at 1 with idx 2 held
    req1 = 4'b0100;
    q1.push_back(0);
    tick();
    rdy1 = 1'b0;
    chk_out("t6_hold", v1, idx1, gnt1, 1, 2);
    rst1 = 1'b0;
    tick();
    chk_out("t6_reset", v1, idx1, gnt1, 0, 0);
    rst1 = 1'b1; req1 = 4'b1111;
    tick();
    chk_out("t6_ptr0", v1, idx1, gnt1, 1, 0);

    // T4 with N = 3
    rst2 = 1'b1;
    tick();
    chk_out("t4n3_first", v2, idx2, {1'b0, gnt2}, 1, 0);
    q2.push_back(0); tick();
    q2.push_back(1); tick();
    q2.push_back(2); tick();
    chk_out("t4n3_wrap", v2, idx2, {1'b0, gnt2}, 1, 0);
    q2.push_back(0); tick();
    q2.push_back(1);
    req2 = 3'b000;
    tick();
    chk_out("t4n3_idle", v2, idx2, {1'b0, gnt2}, 0, 0);

    tick();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
